ws_unit: RTL and testbench
==========================

# ws_unit

Write-S unit for Milestone 2: the writer end of the SRAM ↔ DPRAM block path, the counterpart of the fetch-S′ unit. After the IDCT has left 64 descaled S samples of one 8×8 block in the S DPRAM, this block reads them through both DPRAM ports. It clips each sample to 8 bits, packs pixel pairs and writes the 32 resulting 16-bit words into the Y, U or V region of SRAM at the block's image position. It then pulses done to the Milestone 2 controller.

## Interface
- Parameters
- `Y_BASE`, 18'd0: SRAM word address of Y region (160 words/row)
- `U_BASE`, 18'd38400: SRAM word address of U region (80 words/row)
- `V_BASE`, 18'd57600: SRAM word address of V region (80 words/row)
- Ports
- `CLOCK_50_I` in 1: 50 MHz clock, the block's only clock
- `Resetn` in 1: reset, **synchronous, active-high**: 1 on a rising edge resets the block (port name kept per codebase)
- `WS_start` in 1: start request, sampled in IDLE only
- `WS_seg` in 2: 0 = Y, 1 = U, 2 = V; 3 is invalid
- `WS_RB` in 5: block row, 0..29
- `WS_CB` in 6: block column, 0..39 for Y, 0..19 for U/V
- `WS_read_address_a`, `WS_read_address_b` out 7 each: DPRAM addresses for even and odd samples
- `WS_read_data_a`, `WS_read_data_b` in 32 each: signed S samples, valid one cycle after the address
- `SRAM_address` out 18: SRAM word address
- `SRAM_write_data` out 16: packed pixel pair
- `SRAM_we_n` out 1: write enable, active low
- `WS_done` out 1: one-cycle completion pulse

## Operation
- States: `S_WS_IDLE`, `S_WS_LI0`, `S_WS_LI1`, `S_WS_WRITE`, `S_WS_DONE`.
- IDLE, `WS_start`=1:
  - Latch seg/RB/CB, clear k (0..31), go to LI0.
  - If the inputs are invalid (seg = 3, CB ≥ 40 for Y, CB ≥ 20 for U/V), go directly to DONE and issue no writes.
- LI0: drive read addresses 2k and 2k+1 with k = 0, then go to LI1.
- LI1: drive addresses for k = 1 while data for k = 0 arrives, then go to WRITE.
- WRITE, one SRAM write per cycle:
  - Register address and data for word k, assert `SRAM_we_n`=0.
  - Keep prefetching 2(k+2) and 2(k+2)+1 while those are ≤ 63.
  - After k = 31, go to DONE.
- DONE: `SRAM_we_n`=1, `WS_done`=1 for one cycle, return to IDLE.
- Word k: r = k[4:2], c = k[1:0]. `SRAM_write_data` = {clip(S[2k]), clip(S[2k+1])}, with the even sample in [15:8].
- Address = base + RB·8·W + r·W + CB·4 + c, with W = 160 (Y) or 80 (U/V). The arithmetic is unsigned 18-bit with no overflow over the valid range.
- clip(x): x < 0 → 0; x > 255 → 255; else x[7:0]. The test uses the full 32-bit signed value.
- `WS_start` outside IDLE is ignored. There is no queuing.
- The block only reads the DPRAM. It has no write ports to it.

## Timing
- Reset values: `SRAM_address`=0, `SRAM_write_data`=0, `SRAM_we_n`=1, `WS_done`=0, both read addresses 0, state IDLE, k=0.
- Cycle numbering (`WS_start` sampled at cycle 0):
  - LI0 at cycle 1.
  - Writes for k = 0..31 are visible during cycles 3..34, registered and contiguous, with no bubbles.
  - `WS_done` is high in cycle 35; IDLE from cycle 36.
  - Total latency is 36 cycles from start to return to IDLE.
- Invalid request: `WS_done` high in cycle 1, and `SRAM_we_n` stays 1 throughout.
- Reset asserted mid-operation: at the next edge all outputs take their reset values and the state is IDLE. No partial `WS_done` pulse.
- `WS_start` held high through DONE: no restart until the block is back in IDLE. A new start may be sampled in cycle 36.

## Structure
- The shared state header/package gains `WS_state_type` and the `Y_BASE`/`U_BASE`/`V_BASE` constants next to the existing M2 state types.
- A `clip8` function lives in the package and is reused by later colour-conversion blocks.
- One natural sub-module: `ws_addr_gen`, purely combinational. Inputs are seg/RB/CB/k; output is the 18-bit SRAM address.
- Milestone 2 drives the SRAM address mux from this unit during its write phase.

## Test plan
- Y, RB=0, CB=0, S[i]=i → 32 writes in cycles 3..34:
  - Addresses 0, 1, 2, 3, 160, … with the last at 1123.
  - First data 0x0001, last data 0x3E3F.
  - `WS_done` in cycle 35.
- U, RB=1, CB=2 → first address 39048; word for k=4 at 39128.
- V, RB=29, CB=19 → last address 76799. No address exceeds 76799.
- Clip: S[0..3] = −5, 300, 128, 255 → words 0x00FF, 0x80FF.
- Invalid request: Y with CB=40, or seg=3 → `WS_done` in cycle 1, zero writes.
- Reset at cycle 10 → `SRAM_we_n`=1 next cycle, no `WS_done`. A fresh start then completes a full 32-write block.

Source files
------------

// File: rtl/ws_unit_pkg.sv
// Shared Milestone 2 types and constants for the write-S path: state encoding,
// SRAM region bases and the 8-bit clipping helper.
package ws_unit_pkg;

  typedef enum logic [2:0] {
    S_WS_IDLE,
    S_WS_LI0,
    S_WS_LI1,
    S_WS_WRITE,
    S_WS_DONE
  } WS_state_type;

  localparam logic [17:0] Y_BASE = 18'd0;
  localparam logic [17:0] U_BASE = 18'd38400;
  localparam logic [17:0] V_BASE = 18'd57600;

  localparam logic [1:0] SEG_Y = 2'd0;
  localparam logic [1:0] SEG_U = 2'd1;
  localparam logic [1:0] SEG_V = 2'd2;

  // Saturate a signed 32-bit sample into the 0..255 pixel range.
  function automatic logic [7:0] clip8(input logic signed [31:0] x);
    if (x < 32'sd0) return 8'd0;
    else if (x > 32'sd255) return 8'hFF;
    else return x[7:0];
  endfunction

endpackage

// File: rtl/ws_addr_gen.sv
// Combinational SRAM word address for word k of an 8x8 block at (RB, CB)
// inside the Y, U or V region.
module ws_addr_gen #(
  parameter logic [17:0] Y_BASE = ws_unit_pkg::Y_BASE,
  parameter logic [17:0] U_BASE = ws_unit_pkg::U_BASE,
  parameter logic [17:0] V_BASE = ws_unit_pkg::V_BASE
) (
  input  logic [1:0]  seg,
  input  logic [4:0]  rb,
  input  logic [5:0]  cb,
  input  logic [4:0]  k,
  output logic [17:0] address
);
  import ws_unit_pkg::*;

  logic [17:0] base;
  logic [17:0] row_w;

  always_comb begin
    base  = Y_BASE;
    row_w = 18'd160;
    case (seg)
      SEG_U: begin base = U_BASE; row_w = 18'd80; end
      SEG_V: begin base = V_BASE; row_w = 18'd80; end
      default: begin base = Y_BASE; row_w = 18'd160; end
    endcase
    // Pixel row = 8*RB + r, each word covers two pixels so CB advances by 4.
    address = base + ((18'(rb) << 3) + 18'(k[4:2])) * row_w
            + (18'(cb) << 2) + 18'(k[1:0]);
  end

endmodule

// File: rtl/ws_unit.sv
// Write-S unit: reads 64 S samples from the DPRAM pairwise, clips them to
// 8 bits and writes 32 packed pixel-pair words into SRAM, then pulses done.
module ws_unit #(
  parameter logic [17:0] Y_BASE = ws_unit_pkg::Y_BASE,
  parameter logic [17:0] U_BASE = ws_unit_pkg::U_BASE,
  parameter logic [17:0] V_BASE = ws_unit_pkg::V_BASE
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        WS_start,
  input  logic [1:0]  WS_seg,
  input  logic [4:0]  WS_RB,
  input  logic [5:0]  WS_CB,
  output logic [6:0]  WS_read_address_a,
  output logic [6:0]  WS_read_address_b,
  input  logic [31:0] WS_read_data_a,
  input  logic [31:0] WS_read_data_b,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        WS_done
);
  import ws_unit_pkg::*;

  WS_state_type state, next_state;
  logic [4:0]  k;
  logic [1:0]  seg_q;
  logic [4:0]  rb_q;
  logic [5:0]  cb_q;
  logic        req_ok;
  logic [4:0]  rd_word;
  logic        rd_en;
  logic [4:0]  wr_word;
  logic [17:0] wr_address;

  assign req_ok = ((WS_seg == SEG_Y) && (WS_CB < 6'd40)) ||
                  (((WS_seg == SEG_U) || (WS_seg == SEG_V)) && (WS_CB < 6'd20));

  always_ff @(posedge CLOCK_50_I) begin
    if (Resetn) state <= S_WS_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_WS_IDLE:  if (WS_start) next_state = req_ok ? S_WS_LI0 : S_WS_DONE;
      S_WS_LI0:   next_state = S_WS_LI1;
      S_WS_LI1:   next_state = S_WS_WRITE;
      S_WS_WRITE: if (k == 5'd31) next_state = S_WS_DONE;
      S_WS_DONE:  next_state = S_WS_IDLE;
      default:    next_state = S_WS_IDLE;
    endcase
  end

  // k is the word currently on the SRAM bus during WRITE; read data arriving
  // this cycle belongs to word k+1 (word 0 during LI1).
  always_comb begin
    rd_word = 5'd0;
    rd_en   = 1'b0;
    case (state)
      S_WS_LI0:   begin rd_word = 5'd0; rd_en = 1'b1; end
      S_WS_LI1:   begin rd_word = 5'd1; rd_en = 1'b1; end
      S_WS_WRITE: if (k <= 5'd29) begin rd_word = k + 5'd2; rd_en = 1'b1; end
      default:    begin rd_word = 5'd0; rd_en = 1'b0; end
    endcase
    WS_read_address_a = rd_en ? {1'b0, rd_word, 1'b0} : 7'd0;
    WS_read_address_b = rd_en ? {1'b0, rd_word, 1'b1} : 7'd0;
    wr_word = (state == S_WS_LI1) ? 5'd0 : k + 5'd1;
  end

  ws_addr_gen #(
    .Y_BASE (Y_BASE),
    .U_BASE (U_BASE),
    .V_BASE (V_BASE)
  ) u_addr_gen (
    .seg     (seg_q),
    .rb      (rb_q),
    .cb      (cb_q),
    .k       (wr_word),
    .address (wr_address)
  );

  always_ff @(posedge CLOCK_50_I) begin
    if (Resetn) begin
      k               <= 5'd0;
      seg_q           <= 2'd0;
      rb_q            <= 5'd0;
      cb_q            <= 6'd0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
      WS_done         <= 1'b0;
    end else begin
      case (state)
        S_WS_IDLE: begin
          SRAM_we_n <= 1'b1;
          WS_done   <= 1'b0;
          if (WS_start) begin
            seg_q   <= WS_seg;
            rb_q    <= WS_RB;
            cb_q    <= WS_CB;
            k       <= 5'd0;
            WS_done <= ~req_ok;
          end
        end
        S_WS_LI1, S_WS_WRITE: begin
          if ((state == S_WS_WRITE) && (k == 5'd31)) begin
            SRAM_we_n <= 1'b1;
            WS_done   <= 1'b1;
          end else begin
            SRAM_address    <= wr_address;
            SRAM_write_data <= {clip8(WS_read_data_a), clip8(WS_read_data_b)};
            SRAM_we_n       <= 1'b0;
            k               <= (state == S_WS_LI1) ? 5'd0 : k + 5'd1;
          end
        end
        S_WS_DONE: begin
          SRAM_we_n <= 1'b1;
          WS_done   <= 1'b0;
        end
        default: begin
          SRAM_we_n <= 1'b1;
          WS_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws_unit.sv
// Bench for ws_unit: DPRAM model, reference write list built from the block
// addressing and clipping rules, per-scenario checking tasks.
module tb_ws_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  seg;
  logic [4:0]  rb;
  logic [5:0]  cb;
  logic [6:0]  ra;
  logic [6:0]  rbad;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [17:0] sram_addr;
  logic [15:0] sram_data;
  logic        we_n;
  logic        done;

  logic [31:0] mem [0:127];
  logic [33:0] exp_q[$];
  logic [17:0] obs_addr [0:31];
  logic [15:0] obs_data [0:31];
  int          obs_cnt;
  int          max_addr;
  int          checks;
  int          failures;

  ws_unit dut (
    .CLOCK_50_I        (clk),
    .Resetn            (rst),
    .WS_start          (start),
    .WS_seg            (seg),
    .WS_RB             (rb),
    .WS_CB             (cb),
    .WS_read_address_a (ra),
    .WS_read_address_b (rbad),
    .WS_read_data_a    (rd_a),
    .WS_read_data_b    (rd_b),
    .SRAM_address      (sram_addr),
    .SRAM_write_data   (sram_data),
    .SRAM_we_n         (we_n),
    .WS_done           (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Synchronous-read DPRAM: data one cycle after the address.
  always @(posedge clk) begin
    rd_a <= mem[ra];
    rd_b <= mem[rbad];
  end

  function automatic logic [7:0] clip_ref(input int x);
    logic [31:0] v;
    v = x;
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic int addr_ref(input int s, input int r_b, input int c_b, input int k);
    int base, w;
    base = (s == 0) ? 0 : (s == 1) ? 38400 : 57600;
    w    = (s == 0) ? 160 : 80;
    return base + r_b * 8 * w + (k / 4) * w + c_b * 4 + (k % 4);
  endfunction

  task automatic build_expected(input int s, input int r_b, input int c_b);
    for (int k = 0; k < 32; k++) begin
      logic [17:0] a;
      a = 18'(addr_ref(s, r_b, c_b, k));
      exp_q.push_back({a, clip_ref(int'(mem[2*k])), clip_ref(int'(mem[2*k+1]))});
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 64; i++) begin
      int v;
      v = int'($urandom_range(0, 700)) - 200;
      mem[i] = v;
    end
  endtask

  // Issues one request (start held through nblk back-to-back blocks) and
  // checks every cycle's write strobe, address/data and done pulse.
  task automatic run_block(input logic [1:0] s, input logic [4:0] r_b, input logic [5:0] c_b,
                           input int nblk, input bit ok);
    int period, total;
    period = ok ? 36 : 2;
    total  = period * nblk + 4;
    exp_q.delete();
    obs_cnt  = 0;
    max_addr = 0;
    if (ok) for (int j = 0; j < nblk; j++) build_expected(int'(s), int'(r_b), int'(c_b));
    @(negedge clk);
    seg = s; rb = r_b; cb = c_b; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= total; c++) begin
      int  j, cp;
      bit  exp_we, exp_done;
      logic [33:0] e;
      @(negedge clk);
      start    = (c <= period * (nblk - 1)) ? 1'b1 : 1'b0;
      j        = c / period;
      cp       = c % period;
      exp_we   = ok && (j < nblk) && (cp >= 3) && (cp <= 34);
      exp_done = (j < nblk) && (ok ? (cp == 35) : (cp == 1));
      checks++;
      if (exp_we) begin
        e = exp_q.pop_front();
        if ({we_n, sram_addr, sram_data} !== {1'b0, e}) begin
          failures++;
          $display("FAIL write c=%0d: got we_n=%0b addr=%0d data=%h, want we_n=0 addr=%0d data=%h",
                   c, we_n, sram_addr, sram_data, e[33:16], e[15:0]);
        end
      end else if (we_n !== 1'b1) begin
        failures++;
        $display("FAIL idle_we c=%0d: got we_n=%0b, want 1", c, we_n);
      end
      if (we_n === 1'b0) begin
        if (obs_cnt < 32) begin
          obs_addr[obs_cnt] = sram_addr;
          obs_data[obs_cnt] = sram_data;
        end
        obs_cnt++;
        if (int'(sram_addr) > max_addr) max_addr = int'(sram_addr);
      end
      checks++;
      if (done !== exp_done) begin
        failures++;
        $display("FAIL done c=%0d: got %0b, want %0b", c, done, exp_done);
      end
    end
    checks++;
    if (obs_cnt != (ok ? 32 * nblk : 0)) begin
      failures++;
      $display("FAIL write_count: got %0d, want %0d", obs_cnt, ok ? 32 * nblk : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sram_addr, sram_data, we_n, done, ra, rbad} !== {18'd0, 16'd0, 1'b1, 1'b0, 7'd0, 7'd0}) begin
      failures++;
      $display("FAIL reset_values: got addr=%0d data=%h we_n=%0b done=%0b ra=%0d rb=%0d, want 0 0 1 0 0 0",
               sram_addr, sram_data, we_n, done, ra, rbad);
    end
    rst = 1'b0;
  endtask

  task automatic test_y_ramp();
    for (int i = 0; i < 64; i++) mem[i] = i;
    run_block(2'd0, 5'd0, 6'd0, 1, 1'b1);
    checks++;
    if ({obs_addr[0], obs_addr[1], obs_addr[3], obs_addr[4], obs_addr[31]} !==
        {18'd0, 18'd1, 18'd3, 18'd160, 18'd1123}) begin
      failures++;
      $display("FAIL y_ramp_addr: got %0d %0d %0d %0d %0d, want 0 1 3 160 1123",
               obs_addr[0], obs_addr[1], obs_addr[3], obs_addr[4], obs_addr[31]);
    end
    checks++;
    if ({obs_data[0], obs_data[31]} !== {16'h0001, 16'h3E3F}) begin
      failures++;
      $display("FAIL y_ramp_data: got %h %h, want 0001 3e3f", obs_data[0], obs_data[31]);
    end
  endtask

  task automatic test_u_v();
    load_random();
    run_block(2'd1, 5'd1, 6'd2, 1, 1'b1);
    checks++;
    if ({obs_addr[0], obs_addr[4]} !== {18'd39048, 18'd39128}) begin
      failures++;
      $display("FAIL u_addr: got %0d %0d, want 39048 39128", obs_addr[0], obs_addr[4]);
    end
    load_random();
    run_block(2'd2, 5'd29, 6'd19, 1, 1'b1);
    checks++;
    if (obs_addr[31] !== 18'd76799 || max_addr != 76799) begin
      failures++;
      $display("FAIL v_last_addr: got last=%0d max=%0d, want 76799", obs_addr[31], max_addr);
    end
  endtask

  task automatic test_clip();
    load_random();
    mem[0] = -5; mem[1] = 300; mem[2] = 128; mem[3] = 255;
    run_block(2'd0, 5'd3, 6'd7, 1, 1'b1);
    checks++;
    if ({obs_data[0], obs_data[1]} !== {16'h00FF, 16'h80FF}) begin
      failures++;
      $display("FAIL clip_words: got %h %h, want 00ff 80ff", obs_data[0], obs_data[1]);
    end
  endtask

  task automatic test_invalid();
    load_random();
    run_block(2'd0, 5'd0, 6'd40, 1, 1'b0);
    run_block(2'd3, 5'd2, 6'd1, 1, 1'b0);
    run_block(2'd1, 5'd2, 6'd20, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      logic [1:0] s;
      logic [4:0] r_b;
      logic [5:0] c_b;
      s   = 2'($urandom_range(0, 2));
      r_b = 5'($urandom_range(0, 29));
      c_b = 6'($urandom_range(0, (s == 2'd0) ? 39 : 19));
      load_random();
      run_block(s, r_b, c_b, 1, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    load_random();
    run_block(2'd1, 5'd10, 6'd5, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    int bad_we, bad_done;
    load_random();
    @(negedge clk);
    seg = 2'd0; rb = 5'd4; cb = 6'd9; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (we_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_writing c=10: got we_n=%0b, want 0", we_n);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({we_n, done, sram_addr, sram_data} !== {1'b1, 1'b0, 18'd0, 16'd0}) begin
      failures++;
      $display("FAIL mid_reset: got we_n=%0b done=%0b addr=%0d data=%h, want 1 0 0 0",
               we_n, done, sram_addr, sram_data);
    end
    bad_we = 0; bad_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (we_n !== 1'b1) bad_we++;
      if (done !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_we != 0 || bad_done != 0) begin
      failures++;
      $display("FAIL after_reset_quiet: got we_low=%0d done_high=%0d cycles, want 0 0", bad_we, bad_done);
    end
    run_block(2'd0, 5'd4, 6'd9, 1, 1'b1);
  endtask

  initial begin
    checks = 0; failures = 0;
    start = 1'b0; seg = 2'd0; rb = 5'd0; cb = 6'd0; rst = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    test_reset();
    test_y_ramp();
    test_u_v();
    test_clip();
    test_invalid();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
